// File: rtl/bist_pkg.sv
// Shared definitions for the pattern-generator / MISR BIST block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default widths, the LFSR and MISR tap masks and the controller state encoding.
// The tap masks are written for the default 14-bit pattern and 16-bit signature widths.

package bist_pkg;

    localparam int PAT_W_DEF  = 14;
    localparam int RESP_W_DEF = 8;
    localparam int SIG_W_DEF  = 16;
    localparam int CNT_W_DEF  = 16;

    // Pattern LFSR feedback taps: bits 13, 4, 2, 0.
    localparam logic [13:0] LFSR_TAPS = 14'h2015;

    // MISR feedback taps: bits 15, 14, 12, 3.
    localparam logic [15:0] MISR_TAPS = 16'hD008;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register that compacts cone responses into a signature.
// Latency: a response presented while en is high is folded in at the next rising edge.
// Backpressure: none; one response is absorbed every enabled cycle, and nothing can stall it.
//
// Ports:
//   clk, rst  rising-edge clock, asynchronous active-high reset
//   clr       synchronous clear; it takes priority over en
//   en        absorb resp this cycle
//   resp      cone response, zero-extended to SIG_W (SIG_W must be >= RESP_W)
//   sig       current signature

module bist_misr
    import bist_pkg::*;
#(
    parameter int                 SIG_W  = SIG_W_DEF,
    parameter int                 RESP_W = RESP_W_DEF,
    parameter logic [SIG_W-1:0]   TAPS   = SIG_W'(MISR_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [RESP_W-1:0] resp,
    output logic [SIG_W-1:0]  sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic             fb;

    always_comb begin
        // The feedback bit is the parity of the tapped signature bits.
        fb    = ^(sig_q & TAPS);
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            // Shift and fold the response in. The update has no saturation.
            sig_d = {sig_q[SIG_W-2:0], fb} ^ SIG_W'(resp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_pattern_misr.sv
// Logic BIST controller: drives LFSR patterns into a combinational cone and compacts the responses in a MISR.
// Latency: the first pattern appears one cycle after an accepted start. A run of N vectors reaches DONE N cycles later.
// Backpressure: none. start is ignored while a run is in progress, and the run always completes unless rst is asserted.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        one-cycle run request, accepted in IDLE or DONE
//   seed         LFSR seed, captured on an accepted start; zero is replaced by one
//   num_vectors  number of patterns to apply, captured on an accepted start
//   pat_out      registered pattern that drives the cone inputs
//   resp_in      cone response to the current pat_out, absorbed in the same cycle
//   busy, done   run in progress / signature valid
//   signature    MISR contents

module bist_pattern_misr
    import bist_pkg::*;
#(
    parameter int PAT_W  = PAT_W_DEF,
    parameter int RESP_W = RESP_W_DEF,
    parameter int SIG_W  = SIG_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAT_W-1:0]  seed,
    input  logic [CNT_W-1:0]  num_vectors,
    output logic [PAT_W-1:0]  pat_out,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature
);

    localparam logic [PAT_W-1:0] PAT_TAPS = PAT_W'(LFSR_TAPS);

    bist_state_e       state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  num_q, num_d;

    logic              start_acc;
    logic              last_vec;
    logic              pat_fb;
    logic              misr_clr;
    logic              misr_en;

    // start is only honoured outside RUN, so a stray pulse cannot restart a run in progress.
    always_comb begin
        start_acc = start && (state_q != ST_RUN);
        // num_q is never zero in RUN, so subtracting one cannot underflow there.
        last_vec  = (cnt_q == (num_q - CNT_W'(1)));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // A zero-length run completes at once with an empty signature.
                    state_d = (num_vectors != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_vec) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and control decode.
    always_comb begin
        busy     = (state_q == ST_RUN);
        done     = (state_q == ST_DONE);
        misr_clr = start_acc;
        // The cone has zero latency, so each RUN cycle absorbs the response to the pat_out currently on the bus.
        misr_en  = (state_q == ST_RUN);
    end

    // Pattern LFSR, vector counter and run-length capture.
    always_comb begin
        pat_fb = ^(pat_q & PAT_TAPS);
        pat_d  = pat_q;
        cnt_d  = cnt_q;
        num_d  = num_q;
        if (start_acc) begin
            // An all-zero seed would lock the LFSR at zero.
            pat_d = (seed == '0) ? PAT_W'(1) : seed;
            cnt_d = '0;
            num_d = num_vectors;
        end else if (state_q == ST_RUN) begin
            pat_d = {pat_q[PAT_W-2:0], pat_fb};
            // The count peaks at num_q-1, which is at most 2^CNT_W-2, so it never wraps.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            cnt_q <= '0;
            num_q <= '0;
        end else begin
            pat_q <= pat_d;
            cnt_q <= cnt_d;
            num_q <= num_d;
        end
    end

    bist_misr #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .TAPS   (SIG_W'(MISR_TAPS))
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (misr_clr),
        .en   (misr_en),
        .resp (resp_in),
        .sig  (signature)
    );

    assign pat_out = pat_q;

endmodule

// File: tb/tb_bist_pattern_misr.sv
// Self-checking bench for bist_pattern_misr: directed scenarios plus random runs through a
// stand-in combinational cone, compared against a plain software model of LFSR + MISR.

module tb_bist_pattern_misr;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] seed;
    logic [15:0] num_vectors;
    logic [13:0] pat_out;
    logic [7:0]  resp_in;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    logic        use_cone;
    logic [7:0]  resp_const;

    int          checks;
    int          failures;

    logic [13:0] obs_pats[$];
    logic [13:0] exp_pats[$];
    int          obs_busy;
    int          obs_cycles;
    bit          timed_out;
    logic [15:0] exp_sig;
    logic [13:0] exp_final;

    bist_pattern_misr dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .num_vectors (num_vectors),
        .pat_out     (pat_out),
        .resp_in     (resp_in),
        .busy        (busy),
        .done        (done),
        .signature   (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in cone under test: an arbitrary zero-latency function of the pattern.
    function automatic logic [7:0] cone(input logic [13:0] p);
        logic [7:0] r;
        r[0] = ~(p[0] & p[1]) ^ p[7];
        r[1] = (p[2] | p[3]) & ~p[8];
        r[2] = p[4] ^ p[5] ^ p[9];
        r[3] = ~(p[6] | p[10]) | (p[11] & p[0]);
        r[4] = (p[12] & p[13]) ^ (p[1] | p[5]);
        r[5] = ^p[13:7];
        r[6] = (p[3] & p[9]) | (p[2] & ~p[12]);
        r[7] = ~^p[6:0];
        return r;
    endfunction

    assign resp_in = use_cone ? cone(pat_out) : resp_const;

    // Reference: next pattern = shift left, new LSB = parity of bits 13,4,2,0.
    function automatic logic [13:0] lfsr_next(input logic [13:0] p);
        int fb;
        fb = (int'(p[13]) + int'(p[4]) + int'(p[2]) + int'(p[0])) % 2;
        return 14'((32'(p) << 1) | fb);
    endfunction

    // Reference run: expected pattern list, final signature and final pattern.
    task automatic model(input logic [13:0] s, input int n, input bit cone_on, input logic [7:0] rc);
        logic [13:0] p;
        logic [15:0] sg;
        logic [7:0]  r;
        int          fb;
        exp_pats.delete();
        p  = (s == 14'd0) ? 14'd1 : s;
        sg = 16'd0;
        for (int i = 0; i < n; i++) begin
            exp_pats.push_back(p);
            r  = cone_on ? cone(p) : rc;
            fb = (int'(sg[15]) + int'(sg[14]) + int'(sg[12]) + int'(sg[3])) % 2;
            sg = 16'((32'(sg) << 1) | fb) ^ {8'h00, r};
            p  = lfsr_next(p);
        end
        exp_sig   = sg;
        exp_final = p;
    endtask

    function automatic int first_diff();
        if (obs_pats.size() != exp_pats.size()) return 0;
        foreach (obs_pats[i]) if (obs_pats[i] !== exp_pats[i]) return i;
        return -1;
    endfunction

    // Launches a run and watches it until done. If pulse_at >= 0, a second start is pulsed on
    // that cycle of the run, with different seed and length values.
    task automatic run_vectors(input logic [13:0] s, input logic [15:0] n, input int budget,
                               input int pulse_at);
        @(negedge clk);
        seed        = s;
        num_vectors = n;
        start       = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        obs_pats.delete();
        obs_busy   = 0;
        obs_cycles = 0;
        timed_out  = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                timed_out  = 1'b0;
                obs_cycles = i;
                break;
            end
            if (busy) begin
                obs_busy++;
                obs_pats.push_back(pat_out);
            end
            if (i == pulse_at) begin
                start       = 1'b1;
                seed        = 14'h0007;
                num_vectors = 16'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; seed = '0; num_vectors = '0;
        use_cone = 1'b0; resp_const = 8'hA5;
        repeat (3) @(negedge clk);
        checks++;
        if ({pat_out, signature, busy, done} !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: pat_out=%h sig=%h busy=%b done=%b, required all zero",
                     pat_out, signature, busy, done);
        end
        // Hold start across the release of rst: it must be taken on the very first edge.
        start = 1'b1; seed = 14'h0001; num_vectors = 16'd1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || pat_out !== 14'h0001) begin
            failures++;
            $display("FAIL first_start: busy=%b pat_out=%h, required busy=1 pat_out=0001", busy, pat_out);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || signature !== 16'h00A5) begin
            failures++;
            $display("FAIL first_start_sig: done=%b sig=%h, required done=1 sig=00a5", done, signature);
        end
    endtask

    task automatic test_single_vector;
        use_cone = 1'b0; resp_const = 8'hA5;
        run_vectors(14'h0001, 16'd1, 20, -1);
        checks++;
        if (timed_out || obs_busy != 1 || obs_pats.size() != 1 || obs_pats[0] !== 14'h0001
            || signature !== 16'h00A5) begin
            failures++;
            $display("FAIL single_vector: timeout=%0d busy_cycles=%0d sig=%h, required 0/1/00a5",
                     timed_out, obs_busy, signature);
        end
    endtask

    task automatic test_two_vectors;
        use_cone = 1'b0; resp_const = 8'hA5;
        run_vectors(14'h0001, 16'd2, 20, -1);
        checks++;
        if (timed_out || obs_pats.size() != 2 || obs_pats[0] !== 14'h0001 || obs_pats[1] !== 14'h0003) begin
            failures++;
            $display("FAIL two_vector_pats: timeout=%0d count=%0d, required patterns 0001,0003",
                     timed_out, obs_pats.size());
        end
        checks++;
        if (signature !== 16'h01EF) begin
            failures++;
            $display("FAIL two_vector_sig: sig=%h required 01ef", signature);
        end
    endtask

    task automatic test_zero_seed;
        use_cone = 1'b0; resp_const = 8'h3C;
        run_vectors(14'h0000, 16'd1, 20, -1);
        checks++;
        if (timed_out || obs_pats.size() != 1 || obs_pats[0] !== 14'h0001) begin
            failures++;
            $display("FAIL zero_seed: timeout=%0d count=%0d, required one pattern 0001",
                     timed_out, obs_pats.size());
        end
    endtask

    task automatic test_zero_vectors;
        use_cone = 1'b0; resp_const = 8'hFF;
        run_vectors(14'h0123, 16'd0, 20, -1);
        checks++;
        if (timed_out || obs_cycles != 0 || obs_busy != 0 || signature !== 16'h0000) begin
            failures++;
            $display("FAIL zero_vectors: timeout=%0d done_delay=%0d busy_cycles=%0d sig=%h, required 0/0/0/0000",
                     timed_out, obs_cycles, obs_busy, signature);
        end
    endtask

    task automatic test_start_mid_run;
        use_cone = 1'b1;
        model(14'h2A5B, 20, 1'b1, 8'h00);
        run_vectors(14'h2A5B, 16'd20, 60, 5);
        checks++;
        if (timed_out || obs_busy != 20 || first_diff() != -1 || signature !== exp_sig) begin
            failures++;
            $display("FAIL start_mid_run: timeout=%0d busy_cycles=%0d sig=%h, required 20 cycles sig=%h",
                     timed_out, obs_busy, signature, exp_sig);
        end
    endtask

    task automatic test_reset_mid_run;
        use_cone = 1'b1;
        @(negedge clk);
        seed = 14'h1111; num_vectors = 16'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pat_out, signature, busy, done} !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_run: pat_out=%h sig=%h busy=%b done=%b, required all zero",
                     pat_out, signature, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_cone_1000;
        logic [15:0] first_sig;
        use_cone = 1'b1;
        model(14'h1ACE, 1000, 1'b1, 8'h00);
        run_vectors(14'h1ACE, 16'd1000, 1100, -1);
        checks++;
        if (timed_out || obs_busy != 1000 || obs_cycles != 1000) begin
            failures++;
            $display("FAIL cone_run_len: timeout=%0d busy_cycles=%0d done_delay=%0d, required 1000",
                     timed_out, obs_busy, obs_cycles);
        end
        checks++;
        if (first_diff() != -1) begin
            failures++;
            $display("FAIL cone_patterns: first difference at index %0d", first_diff());
        end
        checks++;
        if (signature !== exp_sig) begin
            failures++;
            $display("FAIL cone_sig: sig=%h required %h", signature, exp_sig);
        end
        first_sig = signature;
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || signature !== exp_sig || pat_out !== exp_final) begin
            failures++;
            $display("FAIL done_hold: done=%b busy=%b sig=%h pat=%h, required 1/0/%h/%h",
                     done, busy, signature, pat_out, exp_sig, exp_final);
        end
        run_vectors(14'h1ACE, 16'd1000, 1100, -1);
        checks++;
        if (timed_out || obs_busy != 1000 || signature !== first_sig) begin
            failures++;
            $display("FAIL rerun_from_done: timeout=%0d busy_cycles=%0d sig=%h, required %h",
                     timed_out, obs_busy, signature, first_sig);
        end
    endtask

    task automatic test_random_runs;
        logic [13:0] s;
        int          n;
        bit          c;
        logic [7:0]  rc;
        for (int k = 0; k < 8; k++) begin
            s  = 14'($urandom);
            n  = int'($urandom_range(1, 150));
            c  = (k % 2) == 0;
            rc = 8'($urandom);
            use_cone = c; resp_const = rc;
            model(s, n, c, rc);
            run_vectors(s, 16'(n), n + 20, -1);
            checks++;
            if (timed_out || obs_busy != n || first_diff() != -1 || signature !== exp_sig
                || pat_out !== exp_final) begin
                failures++;
                $display("FAIL random_run%0d: seed=%h n=%0d timeout=%0d busy_cycles=%0d sig=%h pat=%h, required sig=%h pat=%h",
                         k, s, n, timed_out, obs_busy, signature, pat_out, exp_sig, exp_final);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_vector();
        test_two_vectors();
        test_zero_seed();
        test_zero_vectors();
        test_start_mid_run();
        test_reset_mid_run();
        test_cone_1000();
        test_random_runs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
